// File: rtl/multi_ch_avg_sampler.sv
// Averaging sampler for NUM_CH MCP3201-class 12-bit SPI ADCs that share SCLK and CS_n.
// Define SAMPLER_PEAK_EN to add peak_out, the per-channel maximum code within each block.
`timescale 1ns/1ps
module multi_ch_avg_sampler #(
  parameter int NUM_CH       = 2,
  parameter int LOG2_SAMPLES = 5,
  parameter int CLK_DIV      = 2,
  parameter int CS_IDLE      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 cont,
  output logic                 busy,
  output logic                 new_data,
  output logic [NUM_CH*12-1:0] data_out,
`ifdef SAMPLER_PEAK_EN
  output logic [NUM_CH*12-1:0] peak_out,
`endif
  input  logic [NUM_CH-1:0]    miso,
  output logic                 sclk,
  output logic                 cs_n
);

  localparam int ACC_W = 12 + LOG2_SAMPLES;
  localparam int CNT_W = LOG2_SAMPLES + 1;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(CS_IDLE + 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_SAMPLES) - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(CS_IDLE - 1);
  localparam logic [4:0]       HALF_LAST   = 5'd29;

  typedef enum logic [1:0] {IDLE, FRAME, GAP, DONE} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       half_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic [11:0]      shreg [NUM_CH];
  logic [ACC_W-1:0] acc   [NUM_CH];

  // The shift registers keep only the newest 12 bits, so after 15 captures they hold D11..D0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      busy       <= 1'b0;
      new_data   <= 1'b0;
      data_out   <= '0;
      div_cnt    <= '0;
      half_cnt   <= '0;
      gap_cnt    <= '0;
      sample_cnt <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        shreg[k] <= '0;
        acc[k]   <= '0;
      end
    end else begin
      new_data <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
            sample_cnt <= '0;
            div_cnt    <= '0;
            half_cnt   <= '0;
            cs_n       <= 1'b0;
            busy       <= 1'b1;
            state      <= FRAME;
          end
        end
        FRAME: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              half_cnt   <= '0;
              cs_n       <= 1'b1;
              sclk       <= 1'b0;
              gap_cnt    <= '0;
              sample_cnt <= sample_cnt + 1'b1;
              for (int k = 0; k < NUM_CH; k++) acc[k] <= acc[k] + ACC_W'(shreg[k]);
              state <= (sample_cnt == LAST_SAMPLE) ? DONE : GAP;
            end else begin
              half_cnt <= half_cnt + 5'd1;
              sclk     <= ~sclk;
              if (!sclk) begin
                for (int k = 0; k < NUM_CH; k++) shreg[k] <= {shreg[k][10:0], miso[k]};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            cs_n     <= 1'b0;
            div_cnt  <= '0;
            half_cnt <= '0;
            state    <= FRAME;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DONE: begin
          // Top 12 accumulator bits are the truncated average (acc >> LOG2_SAMPLES).
          for (int k = 0; k < NUM_CH; k++) data_out[12*k +: 12] <= acc[k][ACC_W-1 -: 12];
          new_data <= 1'b1;
          if (cont) begin
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
            sample_cnt <= '0;
            gap_cnt    <= '0;
            state      <= GAP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SAMPLER_PEAK_EN
  logic [11:0] peak [NUM_CH];

  // Peak tracker follows the accumulator lifecycle: cleared at block start, published in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_out <= '0;
      for (int k = 0; k < NUM_CH; k++) peak[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NUM_CH; k++) peak[k] <= '0;
          end
        end
        FRAME: begin
          if (div_cnt == DIV_LAST && half_cnt == HALF_LAST) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (shreg[k] > peak[k]) peak[k] <= shreg[k];
            end
          end
        end
        DONE: begin
          for (int k = 0; k < NUM_CH; k++) peak_out[12*k +: 12] <= peak[k];
          if (cont) begin
            for (int k = 0; k < NUM_CH; k++) peak[k] <= '0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  // Without the peak tracker, frame codes feed only the accumulators.
`endif

endmodule

// File: tb/tb_multi_ch_avg_sampler.sv
// Randomised self-checking bench for multi_ch_avg_sampler: ADC models drive MISO and a
// queue-based reference computes each block's averages (and peaks with SAMPLER_PEAK_EN).
`timescale 1ns/1ps
module tb_multi_ch_avg_sampler;

  localparam int A_CH  = 2;
  localparam int A_L   = 2;
  localparam int A_DIV = 1;
  localparam int A_GAP = 4;
  localparam int A_N   = 1 << A_L;
  localparam int B_CH  = 3;
  localparam int B_L   = 8;
  localparam int B_DIV = 3;
  localparam int B_GAP = 2;
  localparam int B_N   = 1 << B_L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n, start, cont, busy, new_data, sclk, cs_n;
  logic [A_CH*12-1:0]   data_out;
  logic [A_CH-1:0]      miso;
  logic                 rst_n_b, start_b, cont_b, busy_b, new_data_b, sclk_b, cs_n_b;
  logic [B_CH*12-1:0]   data_out_b;
  logic [B_CH-1:0]      miso_b;
`ifdef SAMPLER_PEAK_EN
  logic [A_CH*12-1:0]   peak_out;
  logic [B_CH*12-1:0]   peak_out_b;
`endif

  assign miso_b = {B_CH{1'b1}};

  multi_ch_avg_sampler #(.NUM_CH(A_CH), .LOG2_SAMPLES(A_L), .CLK_DIV(A_DIV), .CS_IDLE(A_GAP)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .busy(busy), .new_data(new_data),
    .data_out(data_out),
`ifdef SAMPLER_PEAK_EN
    .peak_out(peak_out),
`endif
    .miso(miso), .sclk(sclk), .cs_n(cs_n));

  multi_ch_avg_sampler #(.NUM_CH(B_CH), .LOG2_SAMPLES(B_L), .CLK_DIV(B_DIV), .CS_IDLE(B_GAP)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .start(start_b), .cont(cont_b), .busy(busy_b), .new_data(new_data_b),
    .data_out(data_out_b),
`ifdef SAMPLER_PEAK_EN
    .peak_out(peak_out_b),
`endif
    .miso(miso_b), .sclk(sclk_b), .cs_n(cs_n_b));

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    checks++;
    if (got !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, expected);
    end
  endtask

  // Reference state for instance A: codes of every started frame, oldest first.
  logic [23:0] frames_q[$];
  logic [11:0] dir0[$];
  logic [11:0] dir1[$];
  logic [14:0] word [A_CH];
  logic [11:0] code;
  logic [23:0] fr, exp_avg, exp_pk, last_pub;
  int          bitpos, lowcnt, rises, hi_run, nd_a, sum, pk, c;
  bit          prev_cs, prev_sclk, prev_nd, after_frame, nd_in_run;

  always @(negedge clk) begin
    if (!rst_n) begin
      frames_q.delete();
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_nd = 1'b0;
      after_frame = 1'b0; nd_in_run = 1'b0; hi_run = 0; bitpos = 0;
      last_pub = '0;
      miso = '0;
    end else begin
      if (new_data) begin
        nd_a++;
        checkOutput("nd_width", 64'(prev_nd), 0);
        checkOutput("frames_per_block", frames_q.size(), A_N);
        exp_avg = '0; exp_pk = '0;
        if (frames_q.size() >= A_N) begin
          for (int ch = 0; ch < A_CH; ch++) begin
            sum = 0; pk = 0;
            for (int i = 0; i < A_N; i++) begin
              fr = frames_q[i];
              c = int'(fr[12*ch +: 12]);
              sum += c;
              if (c > pk) pk = c;
            end
            exp_avg[12*ch +: 12] = 12'(sum >> A_L);
            exp_pk[12*ch +: 12]  = 12'(pk);
          end
          for (int i = 0; i < A_N; i++) void'(frames_q.pop_front());
        end
        checkOutput("avg", data_out, exp_avg);
`ifdef SAMPLER_PEAK_EN
        checkOutput("peak", peak_out, exp_pk);
`endif
        last_pub = exp_avg;
      end
      if (prev_cs && !cs_n) begin
        if (after_frame) checkOutput("cs_gap", hi_run, A_GAP + (nd_in_run ? 1 : 0));
        after_frame = 1'b0; hi_run = 0; nd_in_run = 1'b0;
        fr = '0;
        for (int ch = 0; ch < A_CH; ch++) begin
          if (ch == 0 && dir0.size() > 0)      code = dir0.pop_front();
          else if (ch == 1 && dir1.size() > 0) code = dir1.pop_front();
          else                                 code = 12'($urandom_range(0, 4095));
          word[ch] = {2'($urandom), 1'b0, code};
          fr[12*ch +: 12] = code;
        end
        frames_q.push_back(fr);
        bitpos = 0; lowcnt = 0; rises = 0;
      end
      if (!cs_n) begin
        lowcnt++;
        if (sclk && !prev_sclk) begin
          rises++;
          bitpos++;
        end
        for (int ch = 0; ch < A_CH; ch++) miso[ch] = (bitpos < 15) ? word[ch][14-bitpos] : 1'b0;
      end else begin
        if (!prev_cs) begin
          checkOutput("cs_low_len", lowcnt, 30*A_DIV);
          checkOutput("sclk_rises", rises, 15);
          checkOutput("sclk_idle", 64'(sclk), 0);
          checkOutput("hold", data_out, last_pub);
          after_frame = 1'b1; hi_run = 0; nd_in_run = 1'b0;
        end
        if (after_frame) begin
          hi_run++;
          if (new_data) nd_in_run = 1'b1;
        end
        if (!busy) after_frame = 1'b0;
        miso = A_CH'($urandom);
      end
      prev_cs = cs_n; prev_sclk = sclk; prev_nd = new_data;
    end
  end

  // Instance B: all-ones inputs, slow SCLK, long averaging block.
  int lowcnt_b, rises_b, hrun_b, bad_b, frames_b;
  bit prev_cs_b, prev_sclk_b, b_done;

  always @(negedge clk) begin
    if (!rst_n_b) begin
      prev_cs_b = 1'b1; prev_sclk_b = 1'b0; frames_b = 0; b_done = 1'b0;
    end else begin
      if (new_data_b) begin
        checkOutput("b_frames", frames_b, B_N);
        checkOutput("b_avg_allones", data_out_b, {B_CH{12'hFFF}});
`ifdef SAMPLER_PEAK_EN
        checkOutput("b_peak_allones", peak_out_b, {B_CH{12'hFFF}});
`endif
        checkOutput("b_busy_end", 64'(busy_b), 0);
        frames_b = 0;
        b_done = 1'b1;
      end
      if (prev_cs_b && !cs_n_b) begin
        lowcnt_b = 0; rises_b = 0; hrun_b = 0; bad_b = 0;
      end
      if (!cs_n_b) begin
        lowcnt_b++;
        if (sclk_b) hrun_b++;
        else begin
          if (hrun_b != 0 && hrun_b != B_DIV) bad_b++;
          hrun_b = 0;
        end
        if (sclk_b && !prev_sclk_b) rises_b++;
      end else if (!prev_cs_b) begin
        if (hrun_b != B_DIV) bad_b++;
        frames_b++;
        checkOutput("b_cs_low_len", lowcnt_b, 30*B_DIV);
        checkOutput("b_rises", rises_b, 15);
        checkOutput("b_half_period", bad_b, 0);
      end
      prev_cs_b = cs_n_b; prev_sclk_b = sclk_b;
    end
  end

  task automatic applyStimulus();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_new_data(input int budget);
    int n = 0;
    while (!new_data && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!new_data) checkOutput("timeout_new_data", 0, 1);
  endtask

  task automatic wait_frame_ends(input int count, input int budget);
    int cnt = 0;
    int t = 0;
    logic prev;
    prev = cs_n;
    while (cnt < count && t < budget) begin
      @(negedge clk);
      t++;
      if (!prev && cs_n) cnt++;
      prev = cs_n;
    end
    if (cnt < count) checkOutput("timeout_frames", cnt, count);
  endtask

  int   r, t, nd_base;
  logic ps;

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    start = 1'b0; cont = 1'b0; start_b = 1'b0; cont_b = 1'b0;
    miso = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", 64'(cs_n), 1);
    checkOutput("rst_sclk", 64'(sclk), 0);
    checkOutput("rst_busy", 64'(busy), 0);
    checkOutput("rst_new_data", 64'(new_data), 0);
    checkOutput("rst_data_out", data_out, 0);
    checkOutput("rst_cs_n_b", 64'(cs_n_b), 1);
    rst_n = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;

    // Constant codes; start during DONE must be ignored.
    for (int i = 0; i < A_N; i++) begin
      dir0.push_back(12'h123);
      dir1.push_back(12'hABC);
    end
    applyStimulus();
    wait_frame_ends(A_N, 2000);
    checkOutput("t1_busy_in_done", 64'(busy), 1);
    checkOutput("t1_nd_in_done", 64'(new_data), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t1_new_data", 64'(new_data), 1);
    checkOutput("t1_data", data_out, 24'hABC123);
    checkOutput("t1_busy_after_done", 64'(busy), 0);
    repeat (20) @(negedge clk);
    checkOutput("t1_start_in_done_ignored", 64'(busy), 0);
    checkOutput("t1_cs_idle", 64'(cs_n), 1);

    // Truncating average of 0,1,2,4.
    dir0.push_back(12'h000); dir0.push_back(12'h001);
    dir0.push_back(12'h002); dir0.push_back(12'h004);
    applyStimulus();
    wait_new_data(2000);
    checkOutput("t2_ch0_avg", data_out[11:0], 12'h001);
`ifdef SAMPLER_PEAK_EN
    checkOutput("t2_ch0_peak", peak_out[11:0], 12'h004);
`endif
    @(negedge clk);

    // Random single-shot blocks.
    for (int b = 0; b < 4; b++) begin
      applyStimulus();
      wait_new_data(2000);
      @(negedge clk);
    end

    // Continuous mode for three blocks with ignored start pulses.
    nd_base = nd_a;
    cont = 1'b1;
    applyStimulus();
    repeat (50) @(negedge clk);
    applyStimulus();
    wait_new_data(2000);
    @(negedge clk);
    repeat (30) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_new_data(2000);
    cont = 1'b0;
    @(negedge clk);
    wait_new_data(2000);
    checkOutput("t4_busy_end", 64'(busy), 0);
    repeat (300) @(negedge clk);
    checkOutput("t4_pulses", nd_a - nd_base, 3);
    checkOutput("t4_idle", 64'(busy), 0);

    // Reset at the 10th SCLK rise of frame 2, then a fresh block.
    applyStimulus();
    wait_frame_ends(1, 500);
    r = 0; t = 0; ps = sclk;
    while (r < 10 && t < 500) begin
      @(negedge clk);
      t++;
      if (!cs_n && sclk && !ps) r++;
      ps = sclk;
    end
    checkOutput("t5_reached_edge10", r, 10);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t5_cs_n", 64'(cs_n), 1);
    checkOutput("t5_sclk", 64'(sclk), 0);
    checkOutput("t5_busy", 64'(busy), 0);
    checkOutput("t5_data_out", data_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < A_N; i++) begin
      dir0.push_back(12'h800);
      dir1.push_back(12'h7FF);
    end
    applyStimulus();
    wait_new_data(2000);
    checkOutput("t5_fresh", data_out, 24'h7FF800);
    @(negedge clk);

    t = 0;
    while (!b_done && t < 40000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("b_finished", 64'(b_done), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
